// File: rtl/mem_rd_arbiter.sv
// Read-port arbiter between the current-block loader and the reference-row
// loader sharing a single memory read port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   curr_req/curr_len     current-block burst request (held until curr_gnt) and length
//   ref_req/ref_len       reference-row burst request (held until ref_gnt) and length
//   ref_urgent            reference loader wins a tie regardless of round-robin order
//   mem_rd_ready          memory accepts the offered read beat this cycle
//   mem_rd_en             read beat offered (a burst is in progress)
//   curr_gnt/ref_gnt      one-cycle registered grant pulse
//   curr_beat/ref_beat    a beat for that owner was accepted this cycle
//   burst_done            registered pulse the cycle after the last beat is accepted
//   owner                 0 = current loader, 1 = reference loader (valid while busy)
//   busy                  same as mem_rd_en
//
// Bursts are never pre-empted. A length of 0 means 64 beats. Every burst ends
// with at least one idle cycle before the next grant.
module mem_rd_arbiter #(
  parameter int unsigned LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             curr_req,
  input  logic [LEN_W-1:0] curr_len,
  input  logic             ref_req,
  input  logic [LEN_W-1:0] ref_len,
  input  logic             ref_urgent,
  input  logic             mem_rd_ready,
  output logic             mem_rd_en,
  output logic             curr_gnt,
  output logic             ref_gnt,
  output logic             curr_beat,
  output logic             ref_beat,
  output logic             burst_done,
  output logic             owner,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle,
    StGntCurr,
    StGntRef
  } state_e;

  localparam logic [LEN_W-1:0] ZeroLenBeats = LEN_W'(64);
  localparam logic [LEN_W-1:0] OneBeat      = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             last_owner_q, last_owner_d;
  logic             burst_done_q, burst_done_d;
  logic             curr_gnt_q, curr_gnt_d;
  logic             ref_gnt_q, ref_gnt_d;
  // Holds off arbitration for the first edge after reset release so the
  // earliest grant lands on the second rising edge.
  logic             armed_q;

  logic             beat_acc;
  logic             pick_ref;

  assign mem_rd_en = (state_q != StIdle);
  assign busy      = mem_rd_en;
  assign owner     = (state_q == StGntRef);
  assign beat_acc  = mem_rd_en & mem_rd_ready;
  assign curr_beat = beat_acc & (state_q == StGntCurr);
  assign ref_beat  = beat_acc & (state_q == StGntRef);

  assign curr_gnt   = curr_gnt_q;
  assign ref_gnt    = ref_gnt_q;
  assign burst_done = burst_done_q;

  // ref wins when it is alone, when urgent, or when curr owned the last burst.
  assign pick_ref = ref_req & (~curr_req | ref_urgent | ~last_owner_q);

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    burst_done_d = 1'b0;
    curr_gnt_d   = 1'b0;
    ref_gnt_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (armed_q && (curr_req || ref_req)) begin
          if (pick_ref) begin
            state_d      = StGntRef;
            ref_gnt_d    = 1'b1;
            last_owner_d = 1'b1;
            beat_cnt_d   = (ref_len == '0) ? ZeroLenBeats : ref_len;
          end else begin
            state_d      = StGntCurr;
            curr_gnt_d   = 1'b1;
            last_owner_d = 1'b0;
            beat_cnt_d   = (curr_len == '0) ? ZeroLenBeats : curr_len;
          end
        end
      end
      StGntCurr, StGntRef: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q - OneBeat;
          if (beat_cnt_q == OneBeat) begin
            state_d      = StIdle;
            burst_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      last_owner_q <= 1'b1;
      burst_done_q <= 1'b0;
      curr_gnt_q   <= 1'b0;
      ref_gnt_q    <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
      burst_done_q <= burst_done_d;
      curr_gnt_q   <= curr_gnt_d;
      ref_gnt_q    <= ref_gnt_d;
      armed_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter: a transaction-level model predicts
// grants, burst lengths and done pulses; a negedge monitor compares.
module tb_mem_rd_arbiter;
  localparam int unsigned LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             curr_req = 1'b0;
  logic [LEN_W-1:0] curr_len = '0;
  logic             ref_req = 1'b0;
  logic [LEN_W-1:0] ref_len = '0;
  logic             ref_urgent = 1'b0;
  logic             mem_rd_ready = 1'b0;
  logic             mem_rd_en, curr_gnt, ref_gnt, curr_beat, ref_beat;
  logic             burst_done, owner, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .curr_req     (curr_req),
    .curr_len     (curr_len),
    .ref_req      (ref_req),
    .ref_len      (ref_len),
    .ref_urgent   (ref_urgent),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_en    (mem_rd_en),
    .curr_gnt     (curr_gnt),
    .ref_gnt      (ref_gnt),
    .curr_beat    (curr_beat),
    .ref_beat     (ref_beat),
    .burst_done   (burst_done),
    .owner        (owner),
    .busy         (busy)
  );

  typedef struct {
    int cyc;
    bit own;
    int beats;
  } gnt_t;

  gnt_t gq[$];   // expected grants: cycle of the pulse, owner, burst length
  int   dq[$];   // expected cycles of burst_done
  int   cyc = 0;

  // Reference model state (transaction level)
  bit m_busy  = 1'b0;
  bit m_own   = 1'b0;
  bit m_last  = 1'b1;
  bit m_armed = 1'b0;
  int m_left  = 0;

  bit c_drop = 1'b0;
  bit r_drop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: cycle %0d t=%0t got %0d expected %0d", nm, cyc, $time, act, exp);
    end
  endtask

  function automatic int beats_of(input logic [LEN_W-1:0] l);
    return (l == '0) ? 64 : int'(l);
  endfunction

  // Model: one step per rising edge using the inputs of the cycle just ended.
  initial begin : model
    bit r;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy  = 1'b0;
        m_left  = 0;
        m_last  = 1'b1;
        m_armed = 1'b0;
      end else begin
        if (m_busy) begin
          if (mem_rd_ready) begin
            m_left--;
            if (m_left == 0) begin
              m_busy = 1'b0;
              dq.push_back(cyc);
            end
          end
        end else if (m_armed && (curr_req || ref_req)) begin
          if (curr_req && ref_req) r = ref_urgent ? 1'b1 : !m_last;
          else r = ref_req;
          m_own  = r;
          m_last = r;
          m_busy = 1'b1;
          m_left = beats_of(r ? ref_len : curr_len);
          gq.push_back('{cyc, r, m_left});
        end
        m_armed = 1'b1;
      end
    end
  end

  initial begin : model_reset
    forever begin
      @(negedge rst_n);
      m_busy  = 1'b0;
      m_left  = 0;
      m_last  = 1'b1;
      m_armed = 1'b0;
      gq.delete();
      dq.delete();
    end
  end

  initial begin : monitor
    int exp_beats;
    int seen;
    bit eg, eo, ed;
    exp_beats = 0;
    seen = 0;
    forever begin
      @(negedge clk);
      eg = (gq.size() > 0) && (gq[0].cyc == cyc);
      eo = eg ? gq[0].own : 1'b0;
      chk("curr_gnt", curr_gnt, eg && !eo);
      chk("ref_gnt", ref_gnt, eg && eo);
      if (eg) begin
        exp_beats = gq[0].beats;
        seen = 0;
        void'(gq.pop_front());
      end
      chk("mem_rd_en", mem_rd_en, m_busy);
      chk("busy", busy, m_busy);
      chk("owner", owner, m_busy && m_own);
      chk("curr_beat", curr_beat, m_busy && !m_own && mem_rd_ready);
      chk("ref_beat", ref_beat, m_busy && m_own && mem_rd_ready);
      if (curr_beat || ref_beat) seen++;
      ed = (dq.size() > 0) && (dq[0] == cyc);
      chk("burst_done", burst_done, ed);
      if (ed) begin
        void'(dq.pop_front());
        chk("burst_beats", seen, exp_beats);
      end
      if (!rst_n) begin
        seen = 0;
        exp_beats = 0;
      end
    end
  end

  // Requesters hold req through their grant cycle, then release it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (c_drop) begin curr_req = 1'b0; c_drop = 1'b0; end
    if (r_drop) begin ref_req = 1'b0; r_drop = 1'b0; end
    if (curr_req && curr_gnt) c_drop = 1'b1;
    if (ref_req && ref_gnt) r_drop = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((curr_req || ref_req || busy || c_drop || r_drop) && n < bound) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= bound) begin
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles (busy=%0b) expected idle", n, busy);
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_gnts", {curr_gnt, ref_gnt}, 0);
    chk("rst_beats", {curr_beat, ref_beat}, 0);
    chk("rst_burst_done", burst_done, 0);
    curr_req = 1'b0;
    ref_req = 1'b0;
    ref_urgent = 1'b0;
    c_drop = 1'b0;
    r_drop = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic [LEN_W-1:0] rand_len();
    if ($urandom_range(0, 9) == 0) return '0;
    return LEN_W'($urandom_range(1, 12));
  endfunction

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single current burst of 4
    tick();
    mem_rd_ready = 1'b1;
    curr_len = 4;
    curr_req = 1'b1;
    wait_idle(50);

    // Round-robin from reset with both requesting continuously
    do_reset();
    mem_rd_ready = 1'b1;
    curr_len = 2;
    ref_len = 2;
    curr_req = 1'b1;
    ref_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!curr_req && !c_drop) curr_req = 1'b1;
      if (!ref_req && !r_drop) ref_req = 1'b1;
    end
    wait_idle(100);

    // Urgent ref wins although ref owned the previous burst
    ref_len = 3;
    ref_req = 1'b1;
    wait_idle(50);
    curr_len = 3;
    ref_len = 3;
    ref_urgent = 1'b1;
    curr_req = 1'b1;
    ref_req = 1'b1;
    wait_idle(100);
    ref_urgent = 1'b0;

    // Zero length means 64 beats, with ready toggling
    ref_len = 0;
    ref_req = 1'b1;
    for (int i = 0; i < 300 && (ref_req || busy || r_drop); i++) begin
      tick();
      mem_rd_ready = ~mem_rd_ready;
    end
    mem_rd_ready = 1'b1;
    wait_idle(50);

    // Reset mid-burst after 3 of 8 beats, then a fresh full burst
    curr_len = 8;
    curr_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      tick();
      if (curr_beat) cnt++;
    end
    do_reset();
    curr_len = 8;
    curr_req = 1'b1;
    wait_idle(60);

    // Curr drops its request mid-burst; urgent ref must wait for completion
    curr_len = 6;
    curr_req = 1'b1;
    for (int i = 0; i < 20 && !curr_gnt; i++) tick();
    tick();
    tick();
    ref_len = 5;
    ref_urgent = 1'b1;
    ref_req = 1'b1;
    for (int i = 0; i < 60 && (ref_req || busy); i++) begin
      tick();
      mem_rd_ready = ($urandom_range(0, 1) == 1);
    end
    mem_rd_ready = 1'b1;
    ref_urgent = 1'b0;
    wait_idle(60);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      tick();
      mem_rd_ready = ($urandom_range(0, 3) != 0);
      ref_urgent = ($urandom_range(0, 3) == 0);
      if (!curr_req && !c_drop && $urandom_range(0, 2) == 0) begin
        curr_len = rand_len();
        curr_req = 1'b1;
      end
      if (!ref_req && !r_drop && $urandom_range(0, 2) == 0) begin
        ref_len = rand_len();
        ref_req = 1'b1;
      end
    end
    mem_rd_ready = 1'b1;
    ref_urgent = 1'b0;
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
